// File: rtl/ps2_key_fifo_if.sv
// Key-event port between the PS/2 receiver FIFO (master) and the processor (slave).
interface ps2_key_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          key_read;
  logic          key_valid;
  logic [7:0]    key_data;
  logic          key_break;
  logic          key_ext;
  logic [CW-1:0] fifo_count;
  logic          frame_error;
  logic          overflow;

  modport master (
    input  key_read,
    output key_valid, key_data, key_break, key_ext, fifo_count, frame_error, overflow
  );

  modport slave (
    output key_read,
    input  key_valid, key_data, key_break, key_ext, fifo_count, frame_error, overflow
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver with F0/E0 prefix folding and a show-ahead key-event FIFO.
module ps2_key_fifo #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_key_fifo_if.master  key
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          clk_prev_r;
  logic          fall_s;
  logic          bit_s;

  rx_state_t     state_r, state_nxt;
  logic [2:0]    bit_cnt_r, bit_cnt_nxt;
  logic [7:0]    shift_r, shift_nxt;
  logic          parity_r, parity_nxt;
  logic [WW-1:0] wd_r, wd_nxt;
  logic          timeout_s;
  logic          byte_done_s;
  logic          frame_err_s;

  logic          pend_brk_r;
  logic          pend_ext_r;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic          ovf_s;
  logic [9:0]    entry_s;

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          frame_error_r;
  logic          overflow_r;
  logic [9:0]    head_s;

  // Two-flop synchronizers plus previous-clock register for fall detection
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r[1];
  assign bit_s  = data_sync_r[1];

  // Receiver state register, shift register and watchdog
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      parity_r  <= 1'b0;
      wd_r      <= {WW{1'b0}};
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      parity_r  <= parity_nxt;
      wd_r      <= wd_nxt;
    end
  end

  // Receiver next-state logic; the watchdog overrides whatever the frame decode wanted
  always_comb begin
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    parity_nxt  = parity_r;
    wd_nxt      = wd_r;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;

    if (fall_s) begin
      wd_nxt = {WW{1'b0}};
    end else if (state_r != ST_IDLE) begin
      wd_nxt = wd_r + WW'(1);
    end else begin
      wd_nxt = {WW{1'b0}};
    end
    timeout_s = (state_r != ST_IDLE) && !fall_s && (wd_r == WW'(TIMEOUT_CYCLES - 1));

    case (state_r)
      ST_IDLE: begin
        if (fall_s && !bit_s) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = 3'd0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_nxt = {bit_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_nxt = ST_PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt_r + 3'd1;
          end
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          parity_nxt = bit_s;
          state_nxt  = ST_STOP;
        end else begin
          state_nxt = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_nxt = ST_IDLE;
          if (bit_s && (^{shift_r, parity_r})) begin
            byte_done_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          state_nxt = ST_STOP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (timeout_s) begin
      state_nxt   = ST_IDLE;
      wd_nxt      = {WW{1'b0}};
      frame_err_s = 1'b1;
    end else begin
      frame_err_s = frame_err_s;
    end
  end

  // Prefix folding and FIFO handshake decode
  always_comb begin
    push_s  = byte_done_s && (shift_r != 8'hF0) && (shift_r != 8'hE0);
    entry_s = {pend_ext_r, pend_brk_r, shift_r};
    pop_s   = key.key_read && (count_r != {CW{1'b0}});
    full_s  = (count_r == CW'(DEPTH));
    // A full FIFO still accepts a push when the head is leaving in the same cycle
    wr_en_s = push_s && (!full_s || pop_s);
    ovf_s   = push_s && full_s && !pop_s;
  end

  // Pending prefix flags
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_brk_r <= 1'b0;
      pend_ext_r <= 1'b0;
    end else if (frame_err_s || ovf_s) begin
      pend_brk_r <= 1'b0;
      pend_ext_r <= 1'b0;
    end else if (byte_done_s) begin
      if (shift_r == 8'hF0) begin
        pend_brk_r <= 1'b1;
      end else if (shift_r == 8'hE0) begin
        pend_ext_r <= 1'b1;
      end else begin
        pend_brk_r <= 1'b0;
        pend_ext_r <= 1'b0;
      end
    end else begin
      pend_brk_r <= pend_brk_r;
      pend_ext_r <= pend_ext_r;
    end
  end

  // FIFO storage (no reset needed; validity is tracked by the count)
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers, occupancy and registered event pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      frame_error_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      frame_error_r <= frame_err_s;
      overflow_r    <= ovf_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_s = (count_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : 10'd0;

  assign key.key_valid   = (count_r != {CW{1'b0}});
  assign key.key_data    = head_s[7:0];
  assign key.key_break   = head_s[8];
  assign key.key_ext     = head_s[9];
  assign key.fifo_count  = count_r;
  assign key.frame_error = frame_error_r;
  assign key.overflow    = overflow_r;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: bit-banged PS/2 frames, prefixes, errors, overflow, timeout, reset.
module tb_ps2_key_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int H     = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int ovf_cnt = 0;
  int bad_head = 0;
  int fe0;
  int ovf0;

  ps2_key_fifo_if #(.DEPTH(DEPTH)) key_if ();

  ps2_key_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (key_if)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (key_if.frame_error) fe_cnt++;
    if (key_if.overflow) ovf_cnt++;
    if (key_if.key_valid && (key_if.key_data == 8'hF0 || key_if.key_data == 8'hE0)) bad_head++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clock);
    ps2_data = b;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  // Full frame; bad_par inverts the parity bit, rd_at_stop pops in the stop-bit fall cycle
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                            input logic rd_at_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    @(negedge clock);
    ps2_data = stop_bit;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    @(negedge clock);
    @(negedge clock);
    if (rd_at_stop) key_if.key_read = 1'b1;
    @(negedge clock);
    key_if.key_read = 1'b0;
    repeat (H - 2) @(negedge clock);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic pop();
    @(negedge clock);
    key_if.key_read = 1'b1;
    @(negedge clock);
    key_if.key_read = 1'b0;
  endtask

  initial begin
    key_if.key_read = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", key_if.key_valid, 0);
    check("rst_count", key_if.fifo_count, 0);
    check("rst_ferr", key_if.frame_error, 0);
    check("rst_ovf", key_if.overflow, 0);
    check("rst_data", key_if.key_data, 0);
    check("rst_brk", key_if.key_break, 0);
    check("rst_ext", key_if.key_ext, 0);

    // Single key
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("single_valid", key_if.key_valid, 1);
    check("single_data", key_if.key_data, 32'h1C);
    check("single_brk", key_if.key_break, 0);
    check("single_ext", key_if.key_ext, 0);
    check("single_count", key_if.fifo_count, 1);
    check("single_ferr", fe_cnt, 0);
    pop();
    check("single_pop_valid", key_if.key_valid, 0);
    check("single_pop_count", key_if.fifo_count, 0);

    // Prefixes
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check("pfx_f0_nopush", key_if.fifo_count, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("pfx_count", key_if.fifo_count, 2);
    check("pfx0", {key_if.key_ext, key_if.key_break, key_if.key_data}, {2'b01, 8'h1C});
    pop();
    check("pfx1", {key_if.key_ext, key_if.key_break, key_if.key_data}, {2'b11, 8'h75});
    pop();
    check("pfx_empty", key_if.fifo_count, 0);

    // Errors
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("err_parity_pulse", fe_cnt - fe0, 1);
    check("err_parity_count", key_if.fifo_count, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("err_stop_pulse", fe_cnt - fe0, 2);
    check("err_stop_count", key_if.fifo_count, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("err_clr_pulse", fe_cnt - fe0, 3);
    check("err_clr_count", key_if.fifo_count, 1);
    check("err_clr_entry", {key_if.key_ext, key_if.key_break, key_if.key_data}, {2'b00, 8'h1C});
    pop();

    // Overflow and wrap
    ovf0 = ovf_cnt;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check("ovf_count", key_if.fifo_count, 8);
    check("ovf_pulse", ovf_cnt - ovf0, 1);
    check("ovf_head", key_if.key_data, 32'h01);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_pop_order", key_if.key_data, i);
      pop();
    end
    check("ovf_drained", key_if.fifo_count, 0);
    for (int i = 8'h11; i <= 8'h18; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check("wrap_count", key_if.fifo_count, 8);
    check("wrap_head", key_if.key_data, 32'h11);

    // Full with simultaneous push and pop
    send_frame(8'h19, 1'b0, 1'b1, 1'b1);
    check("fullpp_ovf", ovf_cnt - ovf0, 1);
    check("fullpp_count", key_if.fifo_count, 8);
    for (int i = 8'h12; i <= 8'h19; i++) begin
      check("fullpp_order", key_if.key_data, i);
      pop();
    end
    check("fullpp_drained", key_if.fifo_count, 0);

    // Timeout: start + 3 data bits then silence
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 3 + TMO; i++) begin
      @(negedge clock);
      if (i == H) ps2_clk = 1'b1;
      if (i == 2 + TMO) check("tmo_not_early", key_if.frame_error, 0);
      if (i == 3 + TMO) check("tmo_exact", key_if.frame_error, 1);
    end
    repeat (3) @(negedge clock);
    check("tmo_one_pulse", fe_cnt - fe0, 1);
    send_frame(8'h2B, 1'b0, 1'b1, 1'b0);
    check("tmo_recover", {key_if.fifo_count, key_if.key_ext, key_if.key_break, key_if.key_data},
          {4'd1, 2'b00, 8'h2B});
    pop();

    // Reset mid-frame with a pending break prefix and a stored entry
    send_frame(8'h33, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    fe0 = fe_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mrst_valid", key_if.key_valid, 0);
    check("mrst_count", key_if.fifo_count, 0);
    check("mrst_head", {key_if.key_ext, key_if.key_break, key_if.key_data}, 0);
    repeat (TMO + 20) @(negedge clock);
    check("mrst_no_ferr", fe_cnt - fe0, 0);
    send_frame(8'h4D, 1'b0, 1'b1, 1'b0);
    check("mrst_next", {key_if.fifo_count, key_if.key_ext, key_if.key_break, key_if.key_data},
          {4'd1, 2'b00, 8'h4D});
    check("no_prefix_heads", bad_head, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
